// File: rtl/cbus_arbiter.sv
// Two-requester memory-bus arbiter (port 0 = ifetch, port 1 = data) with a held grant and a burst beat check.
// Optional macro CBUS_ARB_ROUND_ROBIN_EN replaces the fixed data-first priority with alternating priority.
module cbus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                s_valid,
    input  logic [1:0]                s_is_write,
    input  logic [2*ADDR_WIDTH-1:0]   s_addr,
    input  logic [2*3-1:0]            s_size,
    input  logic [2*LEN_WIDTH-1:0]    s_len,
    input  logic [2*DATA_WIDTH-1:0]   s_data,
    input  logic [2*DATA_WIDTH/8-1:0] s_strb,
    output logic [1:0]                s_okay,
    output logic [1:0]                s_last,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic                      m_valid,
    output logic                      m_is_write,
    output logic [ADDR_WIDTH-1:0]     m_addr,
    output logic [2:0]                m_size,
    output logic [LEN_WIDTH-1:0]      m_len,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic [DATA_WIDTH/8-1:0]   m_strb,
    input  logic                      m_okay,
    input  logic                      m_last,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    output logic                      owner,
    output logic                      busy,
    output logic                      err
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_owner, w_owner_nxt;
    logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 r_err, w_err_set;
    logic                 w_pick;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    assign w_pick = (s_valid == 2'b11) ? ~r_last_owner : s_valid[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last_owner <= 1'b0;
        else if (r_state == IDLE && s_valid != 2'b00)
            r_last_owner <= w_pick;
    end
`else
    assign w_pick = s_valid[1];
`endif

    // Request fields follow the registered owner; requesters hold them stable until their last beat.
    assign m_is_write = r_owner ? s_is_write[1] : s_is_write[0];
    assign m_addr     = r_owner ? s_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_addr[ADDR_WIDTH-1:0];
    assign m_size     = r_owner ? s_size[5:3] : s_size[2:0];
    assign m_len      = r_owner ? s_len[2*LEN_WIDTH-1:LEN_WIDTH] : s_len[LEN_WIDTH-1:0];
    assign m_data     = r_owner ? s_data[2*DATA_WIDTH-1:DATA_WIDTH] : s_data[DATA_WIDTH-1:0];
    assign m_strb     = r_owner ? s_strb[2*STRB_WIDTH-1:STRB_WIDTH] : s_strb[STRB_WIDTH-1:0];
    assign s_rdata    = m_rdata;
    assign owner      = r_owner;
    assign busy       = (r_state == GRANT);
    assign err        = r_err;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        m_valid     = 1'b0;
        s_okay      = 2'b00;
        s_last      = 2'b00;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (s_valid != 2'b00) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_pick;
                end
            end
            GRANT: begin
                m_valid          = s_valid[r_owner];
                s_last[r_owner]  = m_last;
                if (!s_valid[r_owner])
                    w_err_set = 1'b1;
                if (m_okay) begin
                    s_okay[r_owner] = m_valid;
                    if (m_last && r_cnt != m_len)
                        w_err_set = 1'b1;
                    if (!m_last && r_cnt == m_len)
                        w_err_set = 1'b1;
                    if (r_cnt != m_len)
                        w_cnt_nxt = r_cnt + 1'b1;
                    if (m_last)
                        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A handshake with no request outstanding is a slave protocol error.
        if (m_okay && !m_valid)
            w_err_set = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= r_err | w_err_set;
        end
    end
endmodule
